// File: rtl/lvds_tx_if.sv
// Payload handshake into the LVDS transmit framer: the source drives data and valid, and the framer returns ready.
interface lvds_tx_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/lvds_tx_training.sv
// LVDS transmit word framer: training pattern until the far end aligns, then a hold-off, then payload with idle fill.
// One registered word per clk; payload accepted at edge n appears on data_out right after edge n.
module lvds_tx_training #(
  parameter int DATA_WIDTH      = 10,
  parameter int MIN_TRAIN_WORDS = 64,
  parameter int HOLD_WORDS      = 4,
  parameter int TIMEOUT_WORDS   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic                  rx_align_done,
  input  logic                  train_req,
  lvds_tx_if.slave              s,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  training,
  output logic                  link_up,
  output logic                  train_fail
);

  localparam int CW = $clog2(TIMEOUT_WORDS + 1);

  localparam logic [1:0] ST_TRAIN = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_TRAIN_WORDS - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_WORDS - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_WORDS - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;

  // Status and ready are pure decodes of the state register.
  assign s.s_ready = (state == ST_DATA);
  assign link_up   = (state == ST_DATA);
  assign training  = (state == ST_TRAIN) || (state == ST_HOLD);
  assign accept    = (state == ST_DATA) && s.s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_TRAIN;
      cnt        <= '0;
      data_out   <= '0;
      train_fail <= 1'b0;
    end else begin
      train_fail <= 1'b0;
      case (state)
        ST_TRAIN: begin
          data_out <= pattern;
          // Alignment wins over timeout; a retrain request just restarts the pass.
          if (train_req) begin
            cnt <= '0;
          end else if (cnt >= MIN_LAST && rx_align_done) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            train_fail <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          data_out <= pattern;
          if (train_req || !rx_align_done) begin
            state <= ST_TRAIN;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state <= ST_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          // A word handshaken on the exit edge is still transmitted.
          data_out <= accept ? s.s_data : pattern;
          cnt      <= '0;
          if (train_req || !rx_align_done) begin
            state <= ST_TRAIN;
          end
        end
        default: begin
          state    <= ST_TRAIN;
          cnt      <= '0;
          data_out <= pattern;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_tx_training.sv
// Scoreboarded bench for lvds_tx_training: expected words are queued as stimulus is driven and popped after each edge.
module tb_lvds_tx_training;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pat;
  logic       rx_align_done;
  logic       train_req;
  logic [9:0] data_out;
  logic       training;
  logic       link_up;
  logic       train_fail;

  lvds_tx_if #(.DATA_WIDTH(10)) s_if ();

  lvds_tx_training #(
    .DATA_WIDTH(10), .MIN_TRAIN_WORDS(64), .HOLD_WORDS(4), .TIMEOUT_WORDS(1024)
  ) dut (
    .clk(clk), .rst(rst), .pattern(pat), .rx_align_done(rx_align_done),
    .train_req(train_req), .s(s_if), .data_out(data_out), .training(training),
    .link_up(link_up), .train_fail(train_fail)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h000;
    n_cmp++;
    if (data_out !== exp_w) begin
      n_bad++;
      $display("FAIL %s data_out got %h want %h", name, data_out, exp_w);
    end
  endtask

  // Full training pass from TRAIN with cnt=0: 64 pattern words, 4 hold words, then DATA.
  task automatic bring_up(input string name);
    for (int k = 1; k <= 68; k++) begin
      exp_q.push_back(pat);
      tick();
      pop_check(name);
      n_cmp++;
      if (link_up !== (k >= 68)) begin
        n_bad++;
        $display("FAIL %s link_up word %0d got %b want %b", name, k, link_up, (k >= 68));
      end
      n_cmp++;
      if (training !== (k < 68)) begin
        n_bad++;
        $display("FAIL %s training word %0d got %b want %b", name, k, training, (k < 68));
      end
      n_cmp++;
      if (s_if.s_ready !== (k >= 68)) begin
        n_bad++;
        $display("FAIL %s s_ready word %0d got %b want %b", name, k, s_if.s_ready, (k >= 68));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pat = 10'h3E0; rx_align_done = 1'b1; train_req = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_data = 10'h000;
    repeat (3) tick();
    n_cmp++;
    if (data_out !== 10'h000) begin n_bad++; $display("FAIL reset data_out got %h want 000", data_out); end
    n_cmp++;
    if (training !== 1'b1) begin n_bad++; $display("FAIL reset training got %b want 1", training); end
    n_cmp++;
    if (link_up !== 1'b0 || s_if.s_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset link_up/s_ready got %b/%b want 0/0", link_up, s_if.s_ready);
    end
    n_cmp++;
    if (train_fail !== 1'b0) begin n_bad++; $display("FAIL reset train_fail got %b want 0", train_fail); end
    rst = 1'b0;
    bring_up("bringup");
  endtask

  task automatic test_data;
    for (int i = 1; i <= 5; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = 10'(i);
      exp_q.push_back(10'(i));
      tick();
      pop_check("data_word");
      n_cmp++;
      if (s_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL data_ready got %b want 1", s_if.s_ready); end
    end
    s_if.s_valid = 1'b0;
    s_if.s_data  = 10'h0FF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat);
      tick();
      pop_check("idle_fill");
    end
  endtask

  task automatic test_drop_align;
    s_if.s_valid = 1'b1; s_if.s_data = 10'h155; rx_align_done = 1'b0;
    exp_q.push_back(10'h155);
    tick();
    pop_check("drop_exit_word");
    n_cmp++;
    if (s_if.s_ready !== 1'b0) begin n_bad++; $display("FAIL drop_ready got %b want 0", s_if.s_ready); end
    n_cmp++;
    if (training !== 1'b1) begin n_bad++; $display("FAIL drop_training got %b want 1", training); end
    s_if.s_valid = 1'b0; rx_align_done = 1'b1;
    bring_up("drop_retrain");
  endtask

  task automatic test_hold_drop;
    train_req = 1'b1;
    exp_q.push_back(pat);
    tick();
    pop_check("req_exit");
    n_cmp++;
    if (link_up !== 1'b0) begin n_bad++; $display("FAIL req_link_up got %b want 0", link_up); end
    train_req = 1'b0;
    for (int k = 1; k <= 66; k++) begin
      if (k == 66) rx_align_done = 1'b0;
      exp_q.push_back(pat);
      tick();
      pop_check("hold_drop_word");
      n_cmp++;
      if (link_up !== 1'b0) begin n_bad++; $display("FAIL hold_drop_link word %0d got %b want 0", k, link_up); end
    end
    n_cmp++;
    if (training !== 1'b1) begin n_bad++; $display("FAIL hold_drop_training got %b want 1", training); end
    rx_align_done = 1'b1;
    bring_up("hold_drop_retrain");
  endtask

  task automatic test_req_rst;
    train_req = 1'b1;
    exp_q.push_back(pat);
    tick();
    pop_check("req2_exit");
    n_cmp++;
    if (training !== 1'b1 || link_up !== 1'b0) begin
      n_bad++; $display("FAIL req2_state training/link got %b/%b want 1/0", training, link_up);
    end
    train_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) pat = 10'h2AA;
      exp_q.push_back(pat);
      tick();
      pop_check("pattern_change");
    end
    rst = 1'b1;
    exp_q.push_back(10'h000);
    tick();
    pop_check("mid_rst");
    n_cmp++;
    if (training !== 1'b1 || link_up !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst training/link got %b/%b want 1/0", training, link_up);
    end
    rst = 1'b0;
    bring_up("post_rst");
  endtask

  task automatic test_timeout;
    rst = 1'b1; rx_align_done = 1'b0;
    tick();
    rst = 1'b0; pat = 10'h3E0;
    s_if.s_valid = 1'b1; s_if.s_data = 10'h0AB;
    for (int k = 1; k <= 2060; k++) begin
      exp_q.push_back(pat);
      tick();
      pop_check("timeout_word");
      n_cmp++;
      if (s_if.s_ready !== 1'b0) begin n_bad++; $display("FAIL timeout_ready word %0d got %b want 0", k, s_if.s_ready); end
      n_cmp++;
      if (train_fail !== (k == 1024 || k == 2048)) begin
        n_bad++;
        $display("FAIL timeout_pulse word %0d got %b want %b", k, train_fail, (k == 1024 || k == 2048));
      end
    end
  endtask

  initial begin
    test_reset();
    test_data();
    test_drop_align();
    test_hold_drop();
    test_req_rst();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
